shift_unit_pipe: RTL and testbench



---
 rtl/shift_unit_pipe.sv | 124 ++++++++++++
 tb/tb_shift_unit_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined shift unit: operand register, shared right barrel shifter,
// result register. SLL is done by bit-reversing around the right shifter.

module shift_right_log32 (
  input  logic [31:0] din,
  input  logic [4:0]  cntrl,
  input  logic        arith,
  output logic [31:0] dout
);
  logic        fill;
  logic [31:0] v;

  assign fill = arith & din[31];

  // Five logarithmic stages: shift by 1, 2, 4, 8, 16 when the matching cntrl bit is set.
  always_comb begin
    v = din;
    for (int i = 0; i < 5; i++) begin
      if (cntrl[i]) begin
        v = (v >> (1 << i)) | (fill ? ~(32'hFFFF_FFFF >> (1 << i)) : 32'h0);
      end
    end
    dout = v;
  end
endmodule

module shift_unit_pipe #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [XLEN-1:0] op_data,
  input  logic [SHW-1:0]  op_shamt,
  input  logic [1:0]      op_type,
  input  logic [3:0]      op_tag,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic [3:0]      res_tag,
  output logic            res_err,
  output logic            busy
);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b11;
  localparam logic [1:0] OP_ILL = 2'b10;

  logic            s1_valid;
  logic [XLEN-1:0] s1_data;
  logic [SHW-1:0]  s1_shamt;
  logic            s1_arith;
  logic            s1_left;
  logic            s1_err;
  logic [3:0]      s1_tag;

  logic [XLEN-1:0] sh_out;
  logic [XLEN-1:0] shifted;
  logic            s2_load;
  logic            in_xfer;

  function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  assign s2_load  = s1_valid & (~res_valid | res_ready);
  assign op_ready = ~s1_valid | s2_load;
  assign in_xfer  = op_valid & op_ready;
  assign busy     = s1_valid | res_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Operand fields need no reset: they are only observed while s1_valid is set.
  always_ff @(posedge clk) begin
    if (!rst && in_xfer) begin
      s1_data  <= (op_type == OP_SLL) ? bitrev(op_data) : op_data;
      s1_shamt <= op_shamt;
      s1_arith <= (op_type == OP_SRA);
      s1_left  <= (op_type == OP_SLL);
      s1_err   <= (op_type == OP_ILL);
      s1_tag   <= op_tag;
    end
  end

  shift_right_log32 u_shifter (
    .din   (s1_data),
    .cntrl (s1_shamt),
    .arith (s1_arith),
    .dout  (sh_out)
  );

  // Illegal ops pass the operand through untouched (s1_data is not reversed for them).
  always_comb begin
    shifted = s1_left ? bitrev(sh_out) : sh_out;
    if (s1_err) shifted = s1_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_err   <= 1'b0;
    end else if (s2_load) begin
      res_valid <= 1'b1;
      res_data  <= shifted;
      res_tag   <= s1_tag;
      res_err   <= s1_err;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Testbench for shift_unit_pipe: directed steps plus random traffic, checked
// against an item-level queue model of the two-entry pipeline.

module tb_shift_unit_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_data;
  logic [4:0]  op_shamt;
  logic [1:0]  op_type;
  logic [3:0]  op_tag;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic        res_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    int          age;
  } item_t;

  item_t       q[$];
  logic [31:0] last_data;
  logic [3:0]  last_tag;
  logic        last_err;
  int          pops = 0;

  always #5 clk = ~clk;

  shift_unit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .op_shamt  (op_shamt),
    .op_type   (op_type),
    .op_tag    (op_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .res_err   (res_err),
    .busy      (busy)
  );

  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] sh, logic [1:0] t);
    case (t)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b11:   return $signed(d) >>> sh;
      default: return d;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already driven after a negedge; observe, update model, advance.
  task automatic cycle();
    logic  exp_rv, exp_rdy, in_x, out_x;
    item_t it;
    #1;
    exp_rv  = (q.size() > 0) && (q[0].age >= 1);
    exp_rdy = (q.size() < 2) || res_ready;
    chk("op_ready", {31'b0, op_ready}, {31'b0, exp_rdy});
    chk("res_valid", {31'b0, res_valid}, {31'b0, exp_rv});
    chk("busy", {31'b0, busy}, {31'b0, q.size() > 0});
    if (exp_rv) begin
      chk("res_data", res_data, q[0].data);
      chk("res_tag", {28'b0, res_tag}, {28'b0, q[0].tag});
      chk("res_err", {31'b0, res_err}, {31'b0, q[0].err});
    end
    out_x = !rst && exp_rv && res_ready;
    in_x  = !rst && op_valid && exp_rdy;
    it.data = ref_shift(op_data, op_shamt, op_type);
    it.tag  = op_tag;
    it.err  = (op_type == 2'b10);
    it.age  = 0;
    if (out_x) begin
      last_data = res_data;
      last_tag  = res_tag;
      last_err  = res_err;
      pops++;
      void'(q.pop_front());
    end
    @(posedge clk);
    if (rst) q.delete();
    else begin
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (in_x) q.push_back(it);
    end
    @(negedge clk);
  endtask

  task automatic issue(logic [31:0] d, logic [4:0] sh, logic [1:0] t, logic [3:0] tag);
    op_valid = 1'b1;
    op_data  = d;
    op_shamt = sh;
    op_type  = t;
    op_tag   = tag;
    cycle();
    op_valid = 1'b0;
  endtask

  task automatic idle(int n);
    op_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int p0;
    rst       = 1'b1;
    op_valid  = 1'b0;
    op_data   = '0;
    op_shamt  = '0;
    op_type   = 2'b01;
    op_tag    = '0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    chk("reset_res_data", res_data, 32'h0);
    chk("reset_res_tag", {28'b0, res_tag}, 32'h0);

    // Single SLL
    issue(32'h0000_0001, 5'd31, 2'b00, 4'd3);
    idle(3);
    chk("sll31_data", last_data, 32'h8000_0000);
    chk("sll31_tag", {28'b0, last_tag}, 32'd3);
    chk("sll31_err", {31'b0, last_err}, 32'd0);

    // Back-to-back SRA/SRL/SLL
    op_valid = 1'b1;
    op_data  = 32'h8000_00F0;
    op_shamt = 5'd4;
    op_type  = 2'b11; op_tag = 4'd1; cycle();
    op_type  = 2'b01; op_tag = 4'd2; cycle();
    op_type  = 2'b00; op_tag = 4'd4; cycle();
    idle(3);
    chk("b2b_last_data", last_data, 32'h0000_0F00);

    // Backpressure: third op must be refused, then drain in order
    res_ready = 1'b0;
    p0 = pops;
    issue(32'hA5A5_0001, 5'd1, 2'b01, 4'd5);
    issue(32'hA5A5_0002, 5'd2, 2'b11, 4'd6);
    issue(32'hA5A5_0003, 5'd3, 2'b00, 4'd7);
    idle(4);
    res_ready = 1'b1;
    idle(4);
    chk("bp_drain_count", pops - p0, 32'd2);
    chk("bp_last_tag", {28'b0, last_tag}, 32'd6);

    // Illegal op type passes the operand through
    issue(32'h1234_5678, 5'd8, 2'b10, 4'd9);
    idle(3);
    chk("ill_data", last_data, 32'h1234_5678);
    chk("ill_err", {31'b0, last_err}, 32'd1);

    // shamt = 0 is identity for every legal type
    issue(32'hDEAD_BEEF, 5'd0, 2'b00, 4'd10); idle(3);
    chk("sh0_sll", last_data, 32'hDEAD_BEEF);
    issue(32'hDEAD_BEEF, 5'd0, 2'b01, 4'd11); idle(3);
    chk("sh0_srl", last_data, 32'hDEAD_BEEF);
    issue(32'hDEAD_BEEF, 5'd0, 2'b11, 4'd12); idle(3);
    chk("sh0_sra", last_data, 32'hDEAD_BEEF);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      op_valid  = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      op_data   = $urandom;
      op_shamt  = 5'($urandom_range(0, 31));
      op_type   = 2'($urandom_range(0, 3));
      op_tag    = 4'($urandom_range(0, 15));
      cycle();
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    idle(3);

    // Reset while both stages are full and stalled
    res_ready = 1'b0;
    issue(32'h0F0F_0F0F, 5'd4, 2'b01, 4'd13);
    issue(32'hF0F0_F0F0, 5'd4, 2'b11, 4'd14);
    idle(2);
    chk("stall_full_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_ready", {31'b0, op_ready}, 32'd1);
    res_ready = 1'b1;
    p0 = pops;
    idle(4);
    chk("post_rst_no_stale", pops - p0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
